// File: rtl/rv_exec_pkg.sv
// Shared constants, ALU op encoding and instruction field positions for the
// R-type execute/write-back stage.
package rv_exec_pkg;

   localparam int XLEN      = 32;
   localparam int NREG      = 32;
   localparam int REG_IDX_W = $clog2(NREG);

   // Bit positions of the register index fields inside a raw instruction word
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;

   // Decoder op codes; every 3-bit value is a legal operation
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_SLL = 3'd2,
      ALU_SLT = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SRL = 3'd5,
      ALU_OR  = 3'd6,
      ALU_AND = 3'd7
   } alu_op_e;

endpackage

// File: rtl/rv_alu.sv
// Purely combinational integer ALU. Arithmetic wraps modulo 2^XLEN, shifts use
// only the low five bits of b, and slt is a signed compare.
module rv_alu
   import rv_exec_pkg::*;
(
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  alu_op_e         i_op,
   output logic [XLEN-1:0] o_y
);

   logic [4:0] w_shamt;

   assign w_shamt = i_b[4:0];

   // Select the operation result for the current op code
   always_comb begin
      o_y = '0;
      unique case (i_op)
         ALU_ADD: o_y = i_a + i_b;
         ALU_SUB: o_y = i_a - i_b;
         ALU_SLL: o_y = i_a << w_shamt;
         ALU_SLT: o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_XOR: o_y = i_a ^ i_b;
         ALU_SRL: o_y = i_a >> w_shamt;
         ALU_OR:  o_y = i_a | i_b;
         ALU_AND: o_y = i_a & i_b;
         default: o_y = '0;
      endcase
   end

endmodule

// File: rtl/rf_alu_exec_stage.sv
// Execute/write-back stage: register file, ALU, one result register and a
// write-back-to-read bypass so dependent instructions can issue back to back.
module rf_alu_exec_stage
   import rv_exec_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_valid,
   input  logic [31:0]          instructions,
   input  logic [2:0]           operations,
   input  logic                 write_enable,
   output logic [XLEN-1:0]      result,
   output logic                 result_valid,
   output logic [REG_IDX_W-1:0] result_rd,
   input  logic [REG_IDX_W-1:0] dbg_addr,
   output logic [XLEN-1:0]      dbg_data
);

   logic [XLEN-1:0]      r_regFile [NREG];
   logic [XLEN-1:0]      r_result;
   logic                 r_resultValid;
   logic [REG_IDX_W-1:0] r_resultRd;

   logic                 w_accept;
   logic [REG_IDX_W-1:0] w_rs1;
   logic [REG_IDX_W-1:0] w_rs2;
   logic [REG_IDX_W-1:0] w_rd;
   logic [XLEN-1:0]      w_rs1Data;
   logic [XLEN-1:0]      w_rs2Data;
   logic [XLEN-1:0]      w_aluY;
   alu_op_e              w_aluOp;
   logic                 w_wbActive;

   assign w_accept = instr_valid && write_enable;
   assign w_rs1    = instructions[RS1_LSB +: REG_IDX_W];
   assign w_rs2    = instructions[RS2_LSB +: REG_IDX_W];
   assign w_rd     = instructions[RD_LSB  +: REG_IDX_W];
   assign w_aluOp  = alu_op_e'(operations);

   // A pending write-back to x0 is never architecturally visible
   assign w_wbActive = r_resultValid && (r_resultRd != '0);

   // Read ports: x0 is hard-wired to zero, otherwise the pending write-back
   // wins over the stale register file entry
   assign w_rs1Data = (w_rs1 == '0) ? '0 :
                      (w_wbActive && (r_resultRd == w_rs1)) ? r_result : r_regFile[w_rs1];
   assign w_rs2Data = (w_rs2 == '0) ? '0 :
                      (w_wbActive && (r_resultRd == w_rs2)) ? r_result : r_regFile[w_rs2];
   assign dbg_data  = (dbg_addr == '0) ? '0 :
                      (w_wbActive && (r_resultRd == dbg_addr)) ? r_result : r_regFile[dbg_addr];

   rv_alu u_alu (
      .i_a  (w_rs1Data),
      .i_b  (w_rs2Data),
      .i_op (w_aluOp),
      .o_y  (w_aluY)
   );

   // Result register: capture the ALU output of each accepted instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result      <= '0;
         r_resultRd    <= '0;
         r_resultValid <= 1'b0;
      end else begin
         r_resultValid <= w_accept;
         if (w_accept) begin
            r_result   <= w_aluY;
            r_resultRd <= w_rd;
         end
      end
   end

   // Register file: commit the previous cycle's result one edge later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regFile[i] <= '0;
         end
      end else if (w_wbActive) begin
         r_regFile[r_resultRd] <= r_result;
      end
   end

   assign result       = r_result;
   assign result_valid = r_resultValid;
   assign result_rd    = r_resultRd;

endmodule

// File: tb/tb_rf_alu_exec_stage.sv
// Testbench for rf_alu_exec_stage: directed vector table, random instruction
// stream against an architectural register model, and reset corner cases.
module tb_rf_alu_exec_stage;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instructions;
   logic [2:0]  operations;
   logic        write_enable;
   logic [31:0] result;
   logic        result_valid;
   logic [4:0]  result_rd;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int numChecks;
   int numFails;

   // Architectural register state in program order
   logic [31:0] model [32];
   logic [31:0] preVal;

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        we;
      logic [31:0] expResult;
      logic        expValid;
      logic [4:0]  expRd;
   } vec_t;

   vec_t vecs[15];

   rf_alu_exec_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instructions (instructions),
      .operations   (operations),
      .write_enable (write_enable),
      .result       (result),
      .result_valid (result_valid),
      .result_rd    (result_rd),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish, got running, wanted finished");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [31:0] mkInstr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
      return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic vec_t mkVec(input logic [2:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic we, input logic [31:0] expResult,
                                  input logic expValid, input logic [4:0] expRd);
      vec_t v;
      v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.we = we;
      v.expResult = expResult; v.expValid = expValid; v.expRd = expRd;
      return v;
   endfunction

   // Reference ALU in plain integer arithmetic
   function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint unsigned ua, ub, sh;
      longint sa, sb;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = ub % 32;
      case (op)
         3'd0:    return 32'((ua + ub) % (64'd1 << 32));
         3'd1:    return 32'((ua + (64'd1 << 32) - ub) % (64'd1 << 32));
         3'd2:    return 32'((ua * (64'd1 << sh)) % (64'd1 << 32));
         3'd3:    return (sa < sb) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return 32'(ua / (64'd1 << sh));
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      numChecks++;
      if (act !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one instruction and advance to just after the capturing edge
   task automatic applyStimulus(input logic iv, input logic we, input logic [2:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2);
      instr_valid  = iv;
      write_enable = we;
      operations   = op;
      instructions = mkInstr(rd, rs1, rs2);
      @(posedge clk);
      #1;
   endtask

   // Load a register with an arbitrary value by overriding the ALU output
   task automatic preload(input logic [4:0] rd, input logic [31:0] val);
      preVal = val;
      force dut.w_aluY = preVal;
      applyStimulus(1'b1, 1'b1, 3'd0, rd, 5'd0, 5'd0);
      release dut.w_aluY;
      if (rd != 5'd0) model[rd] = val;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
   endtask

   // Compare every register through the debug port
   task automatic sweepRegs(input string tag);
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         #1;
         checkOutput($sformatf("%s_x%0d", tag, a), dbg_data, model[a]);
      end
   endtask

   initial begin
      logic [31:0] holdResult;
      logic [4:0]  holdRd;
      logic [31:0] expY;
      logic        iv, we, acc;
      logic [2:0]  op;
      logic [4:0]  rd, rs1, rs2;

      numChecks    = 0;
      numFails     = 0;
      instr_valid  = 1'b0;
      write_enable = 1'b0;
      operations   = 3'd0;
      instructions = 32'd0;
      dbg_addr     = 5'd0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;

      // Reset state
      rst_n = 1'b0;
      #12;
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
      checkOutput("rst_rd", {27'd0, result_rd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, issued back to back
      preload(5'd1, 32'd5);
      preload(5'd2, 32'd3);
      preload(5'd9, 32'h21);
      vecs[0]  = mkVec(3'd0, 5'd3,  5'd1, 5'd2, 1'b1, 32'd8,        1'b1, 5'd3);
      vecs[1]  = mkVec(3'd1, 5'd4,  5'd2, 5'd1, 1'b1, 32'hFFFFFFFE, 1'b1, 5'd4);
      vecs[2]  = mkVec(3'd3, 5'd5,  5'd4, 5'd0, 1'b1, 32'd1,        1'b1, 5'd5);
      vecs[3]  = mkVec(3'd5, 5'd6,  5'd4, 5'd1, 1'b1, 32'h07FFFFFF, 1'b1, 5'd6);
      vecs[4]  = mkVec(3'd2, 5'd10, 5'd1, 5'd9, 1'b1, 32'd10,       1'b1, 5'd10);
      vecs[5]  = mkVec(3'd0, 5'd7,  5'd1, 5'd1, 1'b1, 32'd10,       1'b1, 5'd7);
      vecs[6]  = mkVec(3'd0, 5'd8,  5'd7, 5'd7, 1'b1, 32'd20,       1'b1, 5'd8);
      vecs[7]  = mkVec(3'd7, 5'd0,  5'd1, 5'd2, 1'b1, 32'd1,        1'b1, 5'd0);
      vecs[8]  = mkVec(3'd6, 5'd11, 5'd0, 5'd2, 1'b1, 32'd3,        1'b1, 5'd11);
      vecs[9]  = mkVec(3'd4, 5'd12, 5'd3, 5'd8, 1'b0, 32'd3,        1'b0, 5'd11);
      vecs[10] = mkVec(3'd4, 5'd12, 5'd3, 5'd8, 1'b1, 32'd28,       1'b1, 5'd12);
      vecs[11] = mkVec(3'd5, 5'd13, 5'd2, 5'd9, 1'b1, 32'd1,        1'b1, 5'd13);
      vecs[12] = mkVec(3'd3, 5'd14, 5'd1, 5'd4, 1'b1, 32'd0,        1'b1, 5'd14);
      vecs[13] = mkVec(3'd3, 5'd15, 5'd4, 5'd1, 1'b1, 32'd1,        1'b1, 5'd15);
      vecs[14] = mkVec(3'd1, 5'd16, 5'd0, 5'd1, 1'b1, 32'hFFFFFFFB, 1'b1, 5'd16);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, vecs[i].we, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
         checkOutput($sformatf("vec%0d_valid", i), {31'd0, result_valid}, {31'd0, vecs[i].expValid});
         checkOutput($sformatf("vec%0d_result", i), result, vecs[i].expResult);
         checkOutput($sformatf("vec%0d_rd", i), {27'd0, result_rd}, {27'd0, vecs[i].expRd});
         if (vecs[i].we && vecs[i].rd != 5'd0) model[vecs[i].rd] = vecs[i].expResult;
         dbg_addr = vecs[i].rd;
         #1;
         checkOutput($sformatf("vec%0d_dbg", i), dbg_data, model[vecs[i].rd]);
      end
      idle();
      sweepRegs("dir");

      // Random instruction stream against the architectural model
      for (int i = 1; i < 32; i++) preload(5'(i), $urandom);
      preload(5'd17, 32'h80000000);
      holdResult = result;
      holdRd     = result_rd;
      for (int n = 0; n < 400; n++) begin
         iv  = ($urandom_range(0, 7) != 0);
         we  = ($urandom_range(0, 7) != 0);
         op  = 3'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 31));
         rs1 = 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         acc = iv && we;
         expY = refAlu(op, model[rs1], model[rs2]);
         applyStimulus(iv, we, op, rd, rs1, rs2);
         if (acc) begin
            holdResult = expY;
            holdRd     = rd;
            if (rd != 5'd0) model[rd] = expY;
         end
         checkOutput($sformatf("rnd%0d_valid", n), {31'd0, result_valid}, {31'd0, acc});
         checkOutput($sformatf("rnd%0d_result", n), result, holdResult);
         checkOutput($sformatf("rnd%0d_rd", n), {27'd0, result_rd}, {27'd0, holdRd});
         dbg_addr = 5'($urandom_range(0, 31));
         #1;
         checkOutput($sformatf("rnd%0d_dbg", n), dbg_data, model[dbg_addr]);
      end
      idle();
      sweepRegs("rnd");

      // Reset asserted while a write-back is pending
      applyStimulus(1'b1, 1'b1, 3'd0, 5'd20, 5'd1, 5'd2);
      instr_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      #1;
      checkOutput("midrst_result", result, 32'd0);
      checkOutput("midrst_valid", {31'd0, result_valid}, 32'd0);
      checkOutput("midrst_rd", {27'd0, result_rd}, 32'd0);
      sweepRegs("inrst");
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      idle();
      sweepRegs("postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
